// File: rtl/ascii_line_if.sv
// Byte-stream in / decoded-line out bundle for ascii_line_decoder.
// The master modport drives the received bytes and observes the results.
interface ascii_line_if #(
  parameter int VALUE_W = 14
);
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic [VALUE_W-1:0] value;
  logic               value_valid;
  logic [2:0]         field_idx;
  logic               record_done;
  logic               err;
  logic [1:0]         err_code;
  logic               busy;

  modport master (
    output rx_data, rx_valid,
    input  value, value_valid, field_idx, record_done, err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output value, value_valid, field_idx, record_done, err, err_code, busy
  );
endinterface

// File: rtl/ascii_line_decoder.sv
// Turns CR-terminated decimal ASCII lines back into binary values and
// groups consecutive lines into fixed-size records.
module ascii_line_decoder #(
  parameter int         MAX_DIGITS        = 4,
  parameter int         VALUE_W           = 14,
  parameter int         FIELDS_PER_RECORD = 2,
  parameter logic [7:0] TERMINATOR        = 8'h0D
) (
  input  logic         clk,
  input  logic         rst,
  ascii_line_if.slave  bus
);

  localparam int                 CNT_W      = $clog2(MAX_DIGITS + 1);
  localparam logic [7:0]         LF         = 8'h0A;
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]         LAST_FIELD = 3'(FIELDS_PER_RECORD - 1);
  localparam logic [VALUE_W+3:0] TEN        = (VALUE_W + 4)'(10);

  typedef enum logic [1:0] {IDLE, ACCUM, DISCARD} state_t;

  typedef enum logic [1:0] {
    ERR_NON_DIGIT = 2'b01,
    ERR_TOO_LONG  = 2'b10,
    ERR_EMPTY     = 2'b11
  } err_code_t;

  state_t             state;
  logic [VALUE_W-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         field_cnt;

  logic [VALUE_W-1:0] value_q;
  logic               value_valid_q;
  logic [2:0]         field_idx_q;
  logic               record_done_q;
  logic               err_q;
  err_code_t          err_code_q;

  logic               is_digit;
  logic               is_term;
  logic               take;
  logic [VALUE_W+3:0] acc_wide;

  always_comb begin
    take     = bus.rx_valid && (bus.rx_data != LF);
    is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    is_term  = (bus.rx_data == TERMINATOR);
    // Low nibble of an ASCII digit is its value; the wide product cannot overflow.
    acc_wide = {4'd0, acc} * TEN + {{VALUE_W{1'b0}}, bus.rx_data[3:0]};
  end

  // NOTE: every register here is updated with <= so all reads in this block
  // see the pre-edge value, matching the hardware regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      field_cnt     <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      field_idx_q   <= '0;
      record_done_q <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= err_code_t'(2'b00);
    end else begin
      value_valid_q <= 1'b0;
      record_done_q <= 1'b0;
      err_q         <= 1'b0;

      if (take) begin
        unique case (state)
          IDLE: begin
            if (is_digit) begin
              acc   <= VALUE_W'(bus.rx_data[3:0]);
              cnt   <= CNT_ONE;
              state <= ACCUM;
            end else if (is_term) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_EMPTY;
              field_cnt  <= '0;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_NON_DIGIT;
              state      <= DISCARD;
            end
          end

          ACCUM: begin
            if (is_digit) begin
              if (cnt == CNT_MAX) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_TOO_LONG;
                state      <= DISCARD;
              end else begin
                acc <= acc_wide[VALUE_W-1:0];
                cnt <= cnt + CNT_ONE;
              end
            end else if (is_term) begin
              value_q       <= acc;
              value_valid_q <= 1'b1;
              field_idx_q   <= field_cnt;
              if (field_cnt == LAST_FIELD) begin
                record_done_q <= 1'b1;
                field_cnt     <= '0;
              end else begin
                field_cnt <= field_cnt + 3'd1;
              end
              state <= IDLE;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_NON_DIGIT;
              state      <= DISCARD;
            end
          end

          DISCARD: begin
            // A broken line loses record alignment, so restart at field 0.
            if (is_term) begin
              field_cnt <= '0;
              state     <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.field_idx   = field_idx_q;
  assign bus.record_done = record_done_q;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.busy        = (state != IDLE);

endmodule
